// File: rtl/board_engine.sv
// Minesweeper board store: WIDTH x HEIGHT saturating cells with WRITE, neighbour-increment
// and CLEAR commands over valid/ready, plus a registered read port.
module board_engine #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CELL_W = 4,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(WIDTH)-1:0]  cmd_x,
  input  logic [$clog2(HEIGHT)-1:0] cmd_y,
  input  logic [CELL_W-1:0]         cmd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      cmd_err,
  input  logic [$clog2(WIDTH)-1:0]  rd_x,
  input  logic [$clog2(HEIGHT)-1:0] rd_y,
  output logic [CELL_W-1:0]         rd_value
);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int CELLS = WIDTH * HEIGHT;
  localparam int AW    = $clog2(CELLS);
  localparam logic [CELL_W-1:0] CELL_MAX = '1;

  typedef enum logic [1:0] {IDLE, INC, CLR} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        slot_reg, slot_next;
  logic [AW-1:0]     clr_reg, clr_next;
  logic [XW-1:0]     cx_reg, cx_next;
  logic [YW-1:0]     cy_reg, cy_next;
  logic              done_next, err_next;

  logic [CELL_W-1:0] mem [CELLS];
  logic              we;
  logic [AW-1:0]     wa;
  logic [CELL_W-1:0] wd;

  logic              accept, cmd_in_range, rd_in_range;
  logic [AW-1:0]     cmd_idx, rd_idx, nb_idx;
  logic [XW-1:0]     nb_x;
  logic [YW-1:0]     nb_y;
  logic              nb_x_ok, nb_y_ok, nb_valid;
  logic [1:0]        dx_sel, dy_sel;
  logic [CELL_W-1:0] nb_cur;

  assign cmd_ready    = (state_reg == IDLE) && reset;
  assign busy         = (state_reg != IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign cmd_in_range = (int'(cmd_x) < WIDTH) && (int'(cmd_y) < HEIGHT);
  assign rd_in_range  = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
  assign cmd_idx      = AW'(int'(cmd_y) * WIDTH + int'(cmd_x));
  assign rd_idx       = rd_in_range ? AW'(int'(rd_y) * WIDTH + int'(rd_x)) : '0;

  // Slot order NW,N,NE,W,E,SW,S,SE; sel 0 = minus one, 1 = same, 2 = plus one
  always_comb begin
    dy_sel = (slot_reg < 3'd3) ? 2'd0 : (slot_reg < 3'd5) ? 2'd1 : 2'd2;
    case (slot_reg)
      3'd0, 3'd3, 3'd5: dx_sel = 2'd0;
      3'd1, 3'd6:       dx_sel = 2'd1;
      default:          dx_sel = 2'd2;
    endcase
  end

  always_comb begin
    nb_x    = cx_reg;
    nb_y    = cy_reg;
    nb_x_ok = 1'b1;
    nb_y_ok = 1'b1;
    if (dx_sel == 2'd0) begin
      if (cx_reg == '0) begin
        nb_x    = XW'(WIDTH - 1);
        nb_x_ok = (WRAP != 0);
      end else begin
        nb_x = cx_reg - XW'(1);
      end
    end else if (dx_sel == 2'd2) begin
      if (int'(cx_reg) == WIDTH - 1) begin
        nb_x    = '0;
        nb_x_ok = (WRAP != 0);
      end else begin
        nb_x = cx_reg + XW'(1);
      end
    end
    if (dy_sel == 2'd0) begin
      if (cy_reg == '0) begin
        nb_y    = YW'(HEIGHT - 1);
        nb_y_ok = (WRAP != 0);
      end else begin
        nb_y = cy_reg - YW'(1);
      end
    end else if (dy_sel == 2'd2) begin
      if (int'(cy_reg) == HEIGHT - 1) begin
        nb_y    = '0;
        nb_y_ok = (WRAP != 0);
      end else begin
        nb_y = cy_reg + YW'(1);
      end
    end
    nb_valid = nb_x_ok && nb_y_ok;
  end

  assign nb_idx = AW'(int'(nb_y) * WIDTH + int'(nb_x));
  assign nb_cur = mem[nb_idx];

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    clr_next   = clr_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    we         = 1'b0;
    wa         = '0;
    wd         = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00: done_next = 1'b1;
            2'b01: begin
              done_next = 1'b1;
              err_next  = !cmd_in_range;
              we        = cmd_in_range;
              wa        = cmd_idx;
              wd        = cmd_data;
            end
            2'b10: begin
              if (cmd_in_range) begin
                state_next = INC;
                slot_next  = '0;
                cx_next    = cmd_x;
                cy_next    = cmd_y;
              end else begin
                done_next = 1'b1;
                err_next  = 1'b1;
              end
            end
            default: begin
              state_next = CLR;
              clr_next   = '0;
            end
          endcase
        end
      end
      INC: begin
        // Off-board slots still consume their cycle so the sequence length is fixed
        we        = nb_valid;
        wa        = nb_idx;
        wd        = (nb_cur == CELL_MAX) ? nb_cur : nb_cur + CELL_W'(1);
        slot_next = slot_reg + 3'd1;
        if (slot_reg == 3'd7) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      CLR: begin
        we       = 1'b1;
        wa       = clr_reg;
        clr_next = clr_reg + AW'(1);
        if (clr_reg == AW'(CELLS - 1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      clr_reg   <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      rd_value  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      clr_reg   <= clr_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      done      <= done_next;
      cmd_err   <= err_next;
      rd_value  <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_board_engine.sv
// Bench for board_engine: an 8x8 bounded board and a 7x5 toroidal board driven by the same
// command stream, each compared against a cell-array reference model.
module tb_board_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_x, cmd_y;
  logic [3:0] cmd_data;
  logic [2:0] rd_x, rd_y;
  logic       cmd_ready_a, busy_a, done_a, cmd_err_a;
  logic       cmd_ready_b, busy_b, done_b, cmd_err_b;
  logic [3:0] rd_value_a, rd_value_b;

  int n_checks = 0;
  int n_errors = 0;

  int mem_m [2][64];
  int mw [2] = '{8, 7};
  int mh [2] = '{8, 5};
  int mwrap [2] = '{0, 1};

  always #5 clk = ~clk;

  board_engine #(.WIDTH(8), .HEIGHT(8), .CELL_W(4), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .busy(busy_a), .done(done_a), .cmd_err(cmd_err_a),
    .rd_x(rd_x), .rd_y(rd_y), .rd_value(rd_value_a)
  );

  board_engine #(.WIDTH(7), .HEIGHT(5), .CELL_W(4), .WRAP(1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .busy(busy_b), .done(done_b), .cmd_err(cmd_err_b),
    .rd_x(rd_x), .rd_y(rd_y), .rd_value(rd_value_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_rd(input int m, input int x, input int y);
    if (x >= mw[m] || y >= mh[m]) return 0;
    return mem_m[m][y * mw[m] + x];
  endfunction

  task automatic model_clear(input int m);
    for (int i = 0; i < 64; i++) mem_m[m][i] = 0;
  endtask

  // Behavioural effect of one command on board m; err reports an out-of-range target
  task automatic model_apply(input int m, input int op, input int x, input int y, input int d,
                             output int err);
    int nx, ny;
    err = 0;
    if ((op == 1 || op == 2) && (x >= mw[m] || y >= mh[m])) begin
      err = 1;
      return;
    end
    if (op == 1) mem_m[m][y * mw[m] + x] = d;
    if (op == 3) model_clear(m);
    if (op == 2) begin
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          if (dx == 0 && dy == 0) continue;
          nx = x + dx;
          ny = y + dy;
          if (mwrap[m] != 0) begin
            nx = (nx + mw[m]) % mw[m];
            ny = (ny + mh[m]) % mh[m];
          end else if (nx < 0 || nx >= mw[m] || ny < 0 || ny >= mh[m]) begin
            continue;
          end
          if (mem_m[m][ny * mw[m] + nx] < 15) mem_m[m][ny * mw[m] + nx]++;
        end
      end
    end
  endtask

  task automatic read_all();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rd_x = 3'(x);
        rd_y = 3'(y);
        @(posedge clk); #1;
        check($sformatf("rd_a(%0d,%0d)", x, y), int'(rd_value_a), model_rd(0, x, y));
        check($sformatf("rd_b(%0d,%0d)", x, y), int'(rd_value_b), model_rd(1, x, y));
      end
    end
  endtask

  task automatic do_cmd(input int op, input int x, input int y, input int d);
    int t, e;
    int exp_err [2];
    int exp_lat [2];
    int first [2];
    int n_done [2];
    int n_err [2];
    int n_busy [2];
    t = 0;
    while (!(cmd_ready_a && cmd_ready_b) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_before_cmd", int'(cmd_ready_a && cmd_ready_b), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_x     = 3'(x);
    cmd_y     = 3'(y);
    cmd_data  = 4'(d);
    for (int m = 0; m < 2; m++) begin
      model_apply(m, op, x, y, d, e);
      exp_err[m] = e;
      exp_lat[m] = (op == 2 && e == 0) ? 8 : (op == 3) ? mw[m] * mh[m] : 0;
      first[m] = -1; n_done[m] = 0; n_err[m] = 0; n_busy[m] = 0;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    for (int n = 0; n < 80; n++) begin
      if (done_a) begin if (n_done[0] == 0) first[0] = n; n_done[0]++; end
      if (done_b) begin if (n_done[1] == 0) first[1] = n; n_done[1]++; end
      if (cmd_err_a) n_err[0]++;
      if (cmd_err_b) n_err[1]++;
      if (busy_a) n_busy[0]++;
      if (busy_b) n_busy[1]++;
      @(posedge clk); #1;
    end
    for (int m = 0; m < 2; m++) begin
      check($sformatf("op%0d(%0d,%0d) done_lat_%0d", op, x, y, m), first[m], exp_lat[m]);
      check($sformatf("op%0d(%0d,%0d) done_cnt_%0d", op, x, y, m), n_done[m], 1);
      check($sformatf("op%0d(%0d,%0d) err_cnt_%0d", op, x, y, m), n_err[m], exp_err[m]);
      check($sformatf("op%0d(%0d,%0d) busy_cyc_%0d", op, x, y, m), n_busy[m], exp_lat[m]);
    end
  endtask

  // Back-to-back writes; the read port watches each target to see old data at the write edge
  task automatic write_burst();
    int xs [6], ys [6], ds [6];
    int e, old_a, old_b;
    xs[0] = 3; ys[0] = 4; ds[0] = 9;
    for (int i = 1; i < 6; i++) begin
      xs[i] = $urandom_range(0, 6);
      ys[i] = $urandom_range(0, 4);
      ds[i] = $urandom_range(1, 15);
    end
    xs[3] = xs[2]; ys[3] = ys[2];
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_x     = 3'(xs[i]);
      cmd_y     = 3'(ys[i]);
      cmd_data  = 4'(ds[i]);
      rd_x      = 3'(xs[i]);
      rd_y      = 3'(ys[i]);
      old_a = model_rd(0, xs[i], ys[i]);
      old_b = model_rd(1, xs[i], ys[i]);
      @(posedge clk); #1;
      check("burst_rd_old_a", int'(rd_value_a), old_a);
      check("burst_rd_old_b", int'(rd_value_b), old_b);
      check("burst_done_a", int'(done_a), 1);
      check("burst_done_b", int'(done_b), 1);
      check("burst_ready_a", int'(cmd_ready_a), 1);
      check("burst_ready_b", int'(cmd_ready_b), 1);
      model_apply(0, 1, xs[i], ys[i], ds[i], e);
      model_apply(1, 1, xs[i], ys[i], ds[i], e);
    end
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    @(posedge clk); #1;
    check("burst_rd_new_a", int'(rd_value_a), model_rd(0, xs[5], ys[5]));
    check("burst_rd_new_b", int'(rd_value_b), model_rd(1, xs[5], ys[5]));
    check("burst_done_end_a", int'(done_a), 0);
  endtask

  initial begin
    int r, op, dn;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_x = 3'd0; cmd_y = 3'd0; cmd_data = 4'd0; rd_x = 3'd0; rd_y = 3'd0;
    model_clear(0);
    model_clear(1);

    @(posedge clk); #1;
    check("ready_in_reset_a", int'(cmd_ready_a), 0);
    @(posedge clk); #1;
    check("busy_after_reset_a", int'(busy_a), 0);
    check("done_after_reset_a", int'(done_a), 0);
    reset = 1'b1;
    #1;
    check("ready_after_release_a", int'(cmd_ready_a), 1);
    check("ready_after_release_b", int'(cmd_ready_b), 1);
    read_all();

    write_burst();
    read_all();

    do_cmd(3, 0, 0, 0);
    do_cmd(2, 0, 0, 0);
    read_all();

    do_cmd(3, 5, 5, 0);
    do_cmd(1, 2, 2, 15);
    do_cmd(2, 3, 3, 0);
    do_cmd(2, 3, 3, 0);
    read_all();

    do_cmd(1, 7, 0, 5);
    do_cmd(2, 0, 6, 0);
    do_cmd(0, 1, 1, 3);
    do_cmd(2, 6, 4, 0);
    read_all();

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
      do_cmd(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
      read_all();
    end

    // Reset in the middle of a CLEAR abandons it without a done pulse
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    dn = 0;
    for (int n = 0; n < 9; n++) begin
      if (done_a || done_b) dn++;
      @(posedge clk); #1;
    end
    check("clr_busy_mid_a", int'(busy_a), 1);
    check("clr_busy_mid_b", int'(busy_b), 1);
    reset = 1'b0;
    #1;
    check("ready_low_in_reset_a", int'(cmd_ready_a), 0);
    @(posedge clk); #1;
    check("busy_cleared_a", int'(busy_a), 0);
    check("busy_cleared_b", int'(busy_b), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear(0);
    model_clear(1);
    for (int n = 0; n < 70; n++) begin
      if (done_a || done_b) dn++;
      @(posedge clk); #1;
    end
    check("no_done_after_abort", dn, 0);
    read_all();
    do_cmd(1, 5, 2, 7);
    read_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
